// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB constants, requester indices and broadcast record
package cdb_pkg;

    localparam int NUM_REQ    = 4;
    localparam int TAG_WIDTH  = 6;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        REQ_INT = 2'd0,
        REQ_MUL = 2'd1,
        REQ_DIV = 2'd2,
        REQ_MEM = 2'd3
    } req_idx_e;

    // One CDB beat as seen by the RS, ROB and register status table
    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - execution-unit request bus and CDB broadcast bus
interface cdb_arbiter_if #(
    parameter int NUM_REQ    = cdb_pkg::NUM_REQ,
    parameter int TAG_WIDTH  = cdb_pkg::TAG_WIDTH,
    parameter int DATA_WIDTH = cdb_pkg::DATA_WIDTH
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][TAG_WIDTH-1:0]  req_tag;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_gnt;
    logic                               ff_tf;
    logic                               flush;
    logic                               cdb_valid;
    logic [TAG_WIDTH-1:0]               cdb_tag;
    logic [DATA_WIDTH-1:0]              cdb_data;
    logic [TAG_WIDTH-1:0]               cdb_tag_tf;
    logic                               cdb_tag_tf_valid;

    modport master (
        output req_valid, req_tag, req_data, ff_tf, flush,
        input  req_gnt, cdb_valid, cdb_tag, cdb_data, cdb_tag_tf, cdb_tag_tf_valid
    );

    modport slave (
        input  req_valid, req_tag, req_data, ff_tf, flush,
        output req_gnt, cdb_valid, cdb_tag, cdb_data, cdb_tag_tf, cdb_tag_tf_valid
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority one-hot arbiter with its own priority pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] idx;
    logic          found;

    // ptr_q is the highest-priority index; scan upward from it with wrap
    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        if (en_i) begin
            for (int k = 0; k < N; k++) begin
                idx = PW'((int'(ptr_q) + k) % N);
                if (!found && req_i[idx]) begin
                    found      = 1'b1;
                    gnt_o[idx] = 1'b1;
                    gnt_idx    = idx;
                end
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB arbiter: gated round-robin grant, result mux and broadcast register
module cdb_arbiter #(
    parameter int NUM_REQ    = cdb_pkg::NUM_REQ,
    parameter int TAG_WIDTH  = cdb_pkg::TAG_WIDTH,
    parameter int DATA_WIDTH = cdb_pkg::DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);
    logic                  grant_en;
    logic [NUM_REQ-1:0]    gnt;
    logic                  valid_q;
    logic                  valid_d;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [TAG_WIDTH-1:0]  tag_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    // A full tag FIFO cannot accept the recycled tag, so nothing may be broadcast
    assign grant_en = rst & ~bus.ff_tf & ~bus.flush;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (grant_en),
        .req_i (bus.req_valid),
        .gnt_o (gnt)
    );

    always_comb begin
        valid_d = |gnt;
        tag_d   = tag_q;
        data_d  = data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                tag_d  = bus.req_tag[i];
                data_d = bus.req_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign bus.req_gnt          = gnt;
    assign bus.cdb_valid        = valid_q;
    assign bus.cdb_tag          = tag_q;
    assign bus.cdb_data         = data_q;
    assign bus.cdb_tag_tf       = tag_q;
    assign bus.cdb_tag_tf_valid = valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - vector table and CDB scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

    cdb_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] v;
        logic       ff;
        logic       fl;
        logic [3:0] gnt;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [5:0]  tag_tab  [4];
    logic [31:0] data_tab [4];
    logic [5:0]  last_tag;
    logic [31:0] last_data;
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(input logic [3:0] v, input logic ff, input logic fl, input logic [3:0] g);
        vec_t t;
        t.v = v; t.ff = ff; t.fl = fl; t.gnt = g;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] g);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                last_tag  = tag_tab[i];
                last_data = data_tab[i];
            end
        end
        e.valid = |g;
        e.tag   = last_tag;
        e.data  = last_data;
        sb.push_back(e);
    endtask

    task automatic check_cdb(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got cdb_valid %0b expected an entry", name, bus.cdb_valid);
        end else begin
            e = sb.pop_front();
            chk({name, ".cdb_valid"}, 64'(bus.cdb_valid), 64'(e.valid));
            chk({name, ".tf_valid"}, 64'(bus.cdb_tag_tf_valid), 64'(e.valid));
            chk({name, ".cdb_tag"}, 64'(bus.cdb_tag), 64'(e.tag));
            chk({name, ".tf_tag"}, 64'(bus.cdb_tag_tf), 64'(e.tag));
            chk({name, ".cdb_data"}, 64'(bus.cdb_data), 64'(e.data));
        end
    endtask

    task automatic cycle(input vec_t t, input string name);
        @(posedge clk);
        #1;
        check_cdb(name);
        bus.req_valid = t.v;
        bus.ff_tf     = t.ff;
        bus.flush     = t.fl;
        #1;
        chk({name, ".gnt"}, 64'(bus.req_gnt), 64'(t.gnt));
        push_exp(t.gnt);
    endtask

    initial begin
        tag_tab[REQ_INT]  = 6'h05; data_tab[REQ_INT] = 32'hDEADBEEF;
        tag_tab[REQ_MUL]  = 6'h2A; data_tab[REQ_MUL] = 32'h12345678;
        tag_tab[REQ_DIV]  = 6'h13; data_tab[REQ_DIV] = 32'hCAFEF00D;
        tag_tab[REQ_MEM]  = 6'h3C; data_tab[REQ_MEM] = 32'h0BADC0DE;
        last_tag  = '0;
        last_data = '0;

        // rr_ptr after each row is noted on the right
        vecs.push_back(mk(4'b0001, 0, 0, 4'b0001)); // 1
        vecs.push_back(mk(4'b0000, 0, 0, 4'b0000)); // 1
        vecs.push_back(mk(4'b1000, 0, 0, 4'b1000)); // 0
        vecs.push_back(mk(4'b1111, 0, 0, 4'b0001)); // 1
        vecs.push_back(mk(4'b1111, 0, 0, 4'b0010)); // 2
        vecs.push_back(mk(4'b1111, 0, 0, 4'b0100)); // 3
        vecs.push_back(mk(4'b1111, 0, 0, 4'b1000)); // 0
        vecs.push_back(mk(4'b1111, 0, 0, 4'b0001)); // 1
        vecs.push_back(mk(4'b0010, 0, 0, 4'b0010)); // 2
        vecs.push_back(mk(4'b0010, 0, 0, 4'b0010)); // 2
        vecs.push_back(mk(4'b0100, 0, 0, 4'b0100)); // 3
        vecs.push_back(mk(4'b0101, 0, 0, 4'b0001)); // 1
        vecs.push_back(mk(4'b0100, 0, 0, 4'b0100)); // 3
        vecs.push_back(mk(4'b0010, 1, 0, 4'b0000)); // 3
        vecs.push_back(mk(4'b0010, 1, 0, 4'b0000)); // 3
        vecs.push_back(mk(4'b0010, 1, 0, 4'b0000)); // 3
        vecs.push_back(mk(4'b0010, 0, 0, 4'b0010)); // 2
        vecs.push_back(mk(4'b0000, 0, 0, 4'b0000)); // 2
        vecs.push_back(mk(4'b1000, 0, 0, 4'b1000)); // 0
        vecs.push_back(mk(4'b0011, 0, 1, 4'b0000)); // 0
        vecs.push_back(mk(4'b0011, 0, 0, 4'b0001)); // 1
        vecs.push_back(mk(4'b0010, 0, 0, 4'b0010)); // 2
        vecs.push_back(mk(4'b0100, 1, 1, 4'b0000)); // 2
        vecs.push_back(mk(4'b0100, 0, 0, 4'b0100)); // 3
        vecs.push_back(mk(4'b0000, 0, 0, 4'b0000)); // 3
        vecs.push_back(mk(4'b0001, 0, 0, 4'b0001)); // 1

        rst           = 1'b0;
        bus.req_valid = 4'b1111;
        bus.ff_tf     = 1'b0;
        bus.flush     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_tag[i]  = tag_tab[i];
            bus.req_data[i] = data_tab[i];
        end

        @(posedge clk);
        #1;
        chk("rst.gnt", 64'(bus.req_gnt), 64'h0);
        chk("rst.cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("rst.tf_valid", 64'(bus.cdb_tag_tf_valid), 64'h0);
        chk("rst.cdb_tag", 64'(bus.cdb_tag), 64'h0);
        chk("rst.cdb_data", 64'(bus.cdb_data), 64'h0);
        bus.req_valid = 4'b0000;
        rst           = 1'b1;
        push_exp(4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-operation: the INT broadcast is visible, then cleared asynchronously
        @(posedge clk);
        #1;
        check_cdb("pre_rst");
        bus.req_valid = 4'b1111;
        #1;
        rst = 1'b0;
        #1;
        chk("midrst.cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("midrst.cdb_tag", 64'(bus.cdb_tag), 64'h0);
        chk("midrst.cdb_data", 64'(bus.cdb_data), 64'h0);
        chk("midrst.gnt", 64'(bus.req_gnt), 64'h0);
        last_tag  = '0;
        last_data = '0;
        @(posedge clk);
        #1;
        chk("midrst.hold_valid", 64'(bus.cdb_valid), 64'h0);
        bus.req_valid = 4'b0011;
        rst           = 1'b1;
        #1;
        chk("postrst.gnt", 64'(bus.req_gnt), 64'(4'b0001));
        push_exp(4'b0001);
        cycle(mk(4'b0010, 0, 0, 4'b0010), "postrst2");
        cycle(mk(4'b0000, 0, 0, 4'b0000), "postrst3");
        @(posedge clk);
        #1;
        check_cdb("drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
